// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the core memory-port arbiter: state encodings,
// default bus widths and the starvation counter width.
package mem_port_arbiter_pkg;

    // Defaults track the core PC width and the instruction fetch bus width.
    localparam int unsigned PC_W        = 64;
    localparam int unsigned INSTR_BUS_W = 64;
    localparam int unsigned ADDR_W_DEF  = PC_W;
    localparam int unsigned DATA_W_DEF  = INSTR_BUS_W;

    localparam logic [ADDR_W_DEF-1:0] ADDR_ZERO = '0;

    // Holds STARVE_MAX up to 15.
    localparam int unsigned STARVE_W = 4;

    // Upper bits name the owner (01 = IFU, 10 = LSU); the low bit is the wait phase.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_IF_REQ  = 3'b010,
        ST_IF_WAIT = 3'b011,
        ST_LS_REQ  = 3'b100,
        ST_LS_WAIT = 3'b101
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive LSU grants taken while a fetch is waiting.
module mem_port_arbiter_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_max
);

    assign at_max = (cnt == STARVE_W'(STARVE_MAX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single core memory port between instruction fetch and load/store,
// one outstanding transaction at a time, LSU priority bounded by a starvation limit.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    input  logic                ifu_flush,
    output logic                ifu_gnt,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_gnt,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t                state;
    state_t                state_nxt;
    logic                  drop;
    logic                  if_ok;
    logic                  lsu_win;
    logic                  ifu_win;
    logic                  starve_at_max;
    logic [STARVE_W-1:0]   starve_cnt;

    assign if_ok   = ifu_req & ~ifu_flush;
    assign lsu_win = (state == ST_IDLE) & lsu_req & ~(if_ok & starve_at_max);
    assign ifu_win = (state == ST_IDLE) & ~lsu_win & if_ok;

    mem_port_arbiter_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clock  (clock),
        .reset  (reset),
        .inc    (lsu_win & if_ok),
        .clr    (ifu_win | ~ifu_req),
        .cnt    (starve_cnt),
        .at_max (starve_at_max)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (lsu_win) begin
                    state_nxt = ST_LS_REQ;
                end else if (ifu_win) begin
                    state_nxt = ST_IF_REQ;
                end
            end
            ST_IF_REQ:  if (mem_ready)  state_nxt = ST_IF_WAIT;
            ST_IF_WAIT: if (mem_rvalid) state_nxt = ST_IDLE;
            ST_LS_REQ:  if (mem_ready)  state_nxt = ST_LS_WAIT;
            ST_LS_WAIT: if (mem_rvalid) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Grants are masked during reset so every output reads 0 while it is held.
    always_comb begin
        ifu_gnt    = ifu_win & ~reset;
        lsu_gnt    = lsu_win & ~reset;
        mem_req    = (state == ST_IF_REQ) || (state == ST_LS_REQ);
        ifu_rvalid = mem_rvalid & (state == ST_IF_WAIT) & ~drop & ~ifu_flush;
        lsu_rvalid = mem_rvalid & (state == ST_LS_WAIT);
        ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
        lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_W'(ADDR_ZERO);
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (lsu_win) begin
            mem_we    <= lsu_we;
            mem_addr  <= lsu_addr;
            mem_wdata <= lsu_wdata;
            mem_wmask <= lsu_wmask;
        end else if (ifu_win) begin
            mem_we    <= 1'b0;
            mem_addr  <= ifu_addr;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end
    end

    // A flushed fetch still finishes on the bus; only its delivery is suppressed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop <= 1'b0;
        end else if (state_nxt == ST_IDLE) begin
            drop <= 1'b0;
        end else if (ifu_flush && (state == ST_IF_REQ || state == ST_IF_WAIT)) begin
            drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned STARVE_MAX = 4;

    logic                clock;
    logic                reset;
    logic                ifu_req;
    logic [ADDR_W-1:0]   ifu_addr;
    logic                ifu_flush;
    logic                ifu_gnt;
    logic                ifu_rvalid;
    logic [DATA_W-1:0]   ifu_rdata;
    logic                lsu_req;
    logic                lsu_we;
    logic [ADDR_W-1:0]   lsu_addr;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic                lsu_gnt;
    logic                lsu_rvalid;
    logic [DATA_W-1:0]   lsu_rdata;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_ready;
    logic                mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;

    int errors = 0;
    int checks = 0;
    bit auto_mem = 0;
    bit pend = 0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ifu_req    (ifu_req),
        .ifu_addr   (ifu_addr),
        .ifu_flush  (ifu_flush),
        .ifu_gnt    (ifu_gnt),
        .ifu_rvalid (ifu_rvalid),
        .ifu_rdata  (ifu_rdata),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_wmask  (lsu_wmask),
        .lsu_gnt    (lsu_gnt),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Random-latency memory: accepts while mem_req is up, answers some cycles later.
    always @(negedge clock) begin
        if (reset || !auto_mem) begin
            pend = 0;
        end else begin
            if (mem_rvalid) pend = 0;
            if (mem_ready) pend = 1;
            mem_ready = 0;
            mem_rvalid = 0;
            mem_rdata = '0;
            if (pend) begin
                if ($urandom_range(0, 1) == 1) begin
                    mem_rvalid = 1;
                    mem_rdata = {$urandom, $urandom};
                end
            end else if (mem_req && $urandom_range(0, 1) == 1) begin
                mem_ready = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        lsu_req = 1; ifu_req = 1; mem_rvalid = 1;
        #1;
        checks++; if (ifu_gnt !== 1'b0) begin errors++; $display("FAIL reset_ifu_gnt: got %0b want 0", ifu_gnt); end
        checks++; if (lsu_gnt !== 1'b0) begin errors++; $display("FAIL reset_lsu_gnt: got %0b want 0", lsu_gnt); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (lsu_rvalid !== 1'b0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b%0b want 00", ifu_rvalid, lsu_rvalid); end
        checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt); end
        cyc();
        lsu_req = 0; ifu_req = 0; mem_rvalid = 0; reset = 0;
        #1;
    endtask

    task automatic test_single_fetch();
        cyc(); ifu_req = 1; ifu_addr = 64'h8000_0000; #1;
        checks++; if (ifu_gnt !== 1'b1 || lsu_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt: got ifu=%0b lsu=%0b want 1/0", ifu_gnt, lsu_gnt); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_c0: got %0b want 0", mem_req); end
        cyc(); ifu_req = 0; ifu_addr = '0; mem_ready = 1; #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0000) begin errors++; $display("FAIL fetch_req_c1: got req=%0b addr=%h want 1/80000000", mem_req, mem_addr); end
        checks++; if (mem_we !== 1'b0 || mem_wmask !== 8'h00) begin errors++; $display("FAIL fetch_fields: got we=%0b wmask=%h want 0/00", mem_we, mem_wmask); end
        cyc(); mem_ready = 0; #1;
        checks++; if (mem_req !== 1'b0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_c2: got req=%0b rvalid=%0b want 0/0", mem_req, ifu_rvalid); end
        cyc(); mem_rvalid = 1; mem_rdata = 64'h0000_0413; #1;
        checks++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'h413) begin errors++; $display("FAIL fetch_rvalid: got %0b/%h want 1/413", ifu_rvalid, ifu_rdata); end
        checks++; if (lsu_rvalid !== 1'b0 || lsu_rdata !== '0 || lsu_gnt !== 1'b0) begin errors++; $display("FAIL fetch_lsu_quiet: got rv=%0b rd=%h gnt=%0b want 0", lsu_rvalid, lsu_rdata, lsu_gnt); end
        cyc(); mem_rvalid = 0; mem_rdata = '0; #1;
        checks++; if (ifu_rvalid !== 1'b0 || ifu_rdata !== '0) begin errors++; $display("FAIL fetch_pulse: got %0b/%h want 0/0", ifu_rvalid, ifu_rdata); end
    endtask

    task automatic test_simultaneous();
        cyc(); ifu_req = 1; ifu_addr = 64'h8000_0004; lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_1000; #1;
        checks++; if (lsu_gnt !== 1'b1 || ifu_gnt !== 1'b0) begin errors++; $display("FAIL simul_first: got lsu=%0b ifu=%0b want 1/0", lsu_gnt, ifu_gnt); end
        cyc(); lsu_req = 0; mem_ready = 1; #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h8000_1000) begin errors++; $display("FAIL simul_lsu_req: got %0b/%h want 1/80001000", mem_req, mem_addr); end
        checks++; if (dut.starve_cnt !== 4'd1) begin errors++; $display("FAIL simul_starve1: got %0d want 1", dut.starve_cnt); end
        cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h1122_3344_5566_7788; #1;
        checks++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL simul_lsu_rv: got %0b/%h", lsu_rvalid, lsu_rdata); end
        checks++; if (ifu_gnt !== 1'b0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL simul_ifu_early: got gnt=%0b rv=%0b want 0/0", ifu_gnt, ifu_rvalid); end
        cyc(); mem_rvalid = 0; mem_rdata = '0; #1;
        checks++; if (ifu_gnt !== 1'b1) begin errors++; $display("FAIL simul_ifu_gnt: got %0b want 1", ifu_gnt); end
        cyc(); ifu_req = 0; mem_ready = 1; #1;
        checks++; if (mem_addr !== 64'h8000_0004 || dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL simul_ifu_req: got %h cnt=%0d want 80000004/0", mem_addr, dut.starve_cnt); end
        cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'hCAFE; #1;
        checks++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'hCAFE) begin errors++; $display("FAIL simul_ifu_rv: got %0b/%h", ifu_rvalid, ifu_rdata); end
        cyc(); mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic test_starvation();
        int seq[$];
        int want[6] = '{1, 1, 1, 1, 0, 1};
        bit got_rv = 0;
        auto_mem = 1;
        cyc(); ifu_req = 1; ifu_addr = 64'h8000_0040; lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_1040;
        for (int c = 0; c < 300 && seq.size() < 6; c++) begin
            #1;
            if (lsu_gnt) seq.push_back(1);
            if (ifu_gnt) seq.push_back(0);
            cyc();
        end
        ifu_req = 0; lsu_req = 0;
        checks++; if (seq.size() != 6) begin errors++; $display("FAIL starve_count: got %0d grants want 6", seq.size()); end
        for (int i = 0; i < seq.size() && i < 6; i++) begin
            checks++; if (seq[i] != want[i]) begin errors++; $display("FAIL starve_order[%0d]: got %s want %s", i, seq[i] ? "LSU" : "IFU", want[i] ? "LSU" : "IFU"); end
        end
        for (int c = 0; c < 100 && !got_rv; c++) begin
            #1;
            if (lsu_rvalid) got_rv = 1; else cyc();
        end
        checks++; if (!got_rv) begin errors++; $display("FAIL starve_drain: got no lsu_rvalid want 1"); end
        cyc(); #1; auto_mem = 0;
    endtask

    task automatic test_flush_in_flight();
        cyc(); ifu_req = 1; ifu_addr = 64'h8000_0100; #1;
        checks++; if (ifu_gnt !== 1'b1) begin errors++; $display("FAIL flush_gnt: got %0b want 1", ifu_gnt); end
        cyc(); ifu_req = 0; ifu_flush = 1; #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL flush_req_kept: got %0b want 1", mem_req); end
        cyc(); ifu_flush = 0; mem_ready = 1; #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0100) begin errors++; $display("FAIL flush_req_hold: got %0b/%h", mem_req, mem_addr); end
        cyc(); mem_ready = 0; ifu_flush = 1; #1;
        cyc(); ifu_flush = 0; mem_rvalid = 1; mem_rdata = 64'hBAD; #1;
        checks++; if (ifu_rvalid !== 1'b0 || ifu_rdata !== '0) begin errors++; $display("FAIL flush_dropped: got %0b/%h want 0/0", ifu_rvalid, ifu_rdata); end
        cyc(); mem_rvalid = 0; mem_rdata = '0; lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_1008; #1;
        checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL flush_next_gnt: got %0b want 1", lsu_gnt); end
        cyc(); lsu_req = 0; mem_ready = 1;
        cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h77; #1;
        checks++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 64'h77) begin errors++; $display("FAIL flush_next_rv: got %0b/%h want 1/77", lsu_rvalid, lsu_rdata); end
        cyc(); mem_rvalid = 0; mem_rdata = '0; ifu_req = 1; ifu_addr = 64'h8000_0108;
        cyc(); ifu_req = 0; mem_ready = 1;
        cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h55; #1;
        checks++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'h55) begin errors++; $display("FAIL flush_refetch: got %0b/%h want 1/55", ifu_rvalid, ifu_rdata); end
        cyc(); mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic test_store_stall();
        cyc(); lsu_req = 1; lsu_we = 1; lsu_addr = 64'h8000_2000; lsu_wdata = 64'hDEAD_BEEF_0000_0001; lsu_wmask = 8'h0F; #1;
        checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt: got %0b want 1", lsu_gnt); end
        cyc(); lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '1; lsu_wmask = 8'hF0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3); #1;
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 64'h8000_2000, 64'hDEAD_BEEF_0000_0001, 8'h0F}) begin
                errors++; $display("FAIL store_stable[%0d]: got %0b %0b %h %h %h", k, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
            end
            cyc();
        end
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h5A; #1;
        checks++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 64'h5A || mem_req !== 1'b0) begin errors++; $display("FAIL store_done: got rv=%0b rd=%h req=%0b", lsu_rvalid, lsu_rdata, mem_req); end
        cyc(); mem_rvalid = 0; mem_rdata = '0; lsu_wdata = '0; lsu_wmask = '0;
    endtask

    task automatic test_reset_mid();
        cyc(); lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_3000; #1;
        checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %0b want 1", lsu_gnt); end
        cyc(); lsu_req = 0; mem_ready = 1;
        cyc(); mem_ready = 0; #1;
        reset = 1; mem_rvalid = 1; mem_rdata = 64'h99; lsu_req = 1; #1;
        checks++; if (lsu_rvalid !== 1'b0 || lsu_rdata !== '0) begin errors++; $display("FAIL rstmid_rvalid: got %0b/%h want 0/0", lsu_rvalid, lsu_rdata); end
        checks++; if (lsu_gnt !== 1'b0 || ifu_gnt !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got %0b%0b%0b want 000", lsu_gnt, ifu_gnt, mem_req); end
        checks++; if (mem_addr !== '0 || mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_fields: got %h/%0b want 0/0", mem_addr, mem_we); end
        cyc(); reset = 0; lsu_req = 0; #1;
        checks++; if (lsu_rvalid !== 1'b0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_late_rsp: got %0b%0b want 00", lsu_rvalid, ifu_rvalid); end
        cyc(); mem_rvalid = 0; mem_rdata = '0; ifu_req = 1; ifu_addr = 64'h8000_0200; #1;
        checks++; if (ifu_gnt !== 1'b1 || lsu_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_ifu_gnt: got %0b/%0b want 1/0", ifu_gnt, lsu_gnt); end
        cyc(); ifu_req = 0; mem_ready = 1; #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0200) begin errors++; $display("FAIL rstmid_ifu_req: got %0b/%h", mem_req, mem_addr); end
        cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h13; #1;
        checks++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'h13) begin errors++; $display("FAIL rstmid_ifu_rv: got %0b/%h want 1/13", ifu_rvalid, ifu_rdata); end
        cyc(); mem_rvalid = 0; mem_rdata = '0;
    endtask

    // Reference model: one transaction record (owner, accepted, dropped) plus a starvation tally.
    task automatic test_random();
        bit m_busy = 0, m_lsu = 0, m_acc = 0, m_drop = 0;
        int m_starve = 0;
        logic [ADDR_W-1:0] m_addr = '0;
        logic m_we = 0;
        logic [DATA_W-1:0] m_wdata = '0;
        logic [DATA_W/8-1:0] m_wmask = '0;
        bit if_ok, e_lgnt, e_ignt, e_req, e_irv, e_lrv, prev_ignt = 0, prev_lgnt = 0, gen;
        bit finished = 0;
        auto_mem = 1;
        cyc();
        for (int c = 0; c < 4000 && !finished; c++) begin
            gen = (c < 2000);
            if (!gen && !m_busy && !ifu_req && !lsu_req) begin
                finished = 1;
            end else begin
                if (!ifu_req || prev_ignt) begin
                    ifu_req = gen && ($urandom_range(0, 2) != 0);
                    ifu_addr = {$urandom, $urandom};
                end
                if (!lsu_req || prev_lgnt) begin
                    lsu_req = gen && ($urandom_range(0, 2) != 0);
                    lsu_we = $urandom_range(0, 1) == 1;
                    lsu_addr = {$urandom, $urandom};
                    lsu_wdata = {$urandom, $urandom};
                    lsu_wmask = 8'($urandom);
                end
                ifu_flush = gen && ($urandom_range(0, 7) == 0);
                #1;
                if_ok = ifu_req && !ifu_flush;
                e_lgnt = !m_busy && lsu_req && !(if_ok && m_starve == STARVE_MAX);
                e_ignt = !m_busy && !e_lgnt && if_ok;
                e_req = m_busy && !m_acc;
                e_irv = m_busy && m_acc && !m_lsu && mem_rvalid && !m_drop && !ifu_flush;
                e_lrv = m_busy && m_acc && m_lsu && mem_rvalid;
                checks++; if (mem_rvalid && !(m_busy && m_acc)) begin errors++; $display("FAIL rnd_protocol c%0d: got mem_rvalid=1 outside wait", c); end
                checks++; if (ifu_gnt !== e_ignt || lsu_gnt !== e_lgnt) begin errors++; $display("FAIL rnd_gnt c%0d: got ifu=%0b lsu=%0b want %0b/%0b", c, ifu_gnt, lsu_gnt, e_ignt, e_lgnt); end
                checks++; if (mem_req !== e_req) begin errors++; $display("FAIL rnd_mem_req c%0d: got %0b want %0b", c, mem_req, e_req); end
                if (e_req) begin
                    checks++; if (mem_addr !== m_addr || mem_we !== m_we || mem_wmask !== m_wmask || (m_lsu && mem_wdata !== m_wdata)) begin
                        errors++; $display("FAIL rnd_fields c%0d: got %h/%0b/%h/%h want %h/%0b/%h/%h", c, mem_addr, mem_we, mem_wmask, mem_wdata, m_addr, m_we, m_wmask, m_wdata);
                    end
                end
                checks++; if (ifu_rvalid !== e_irv || ifu_rdata !== (e_irv ? mem_rdata : '0)) begin errors++; $display("FAIL rnd_ifu_rsp c%0d: got %0b/%h want %0b", c, ifu_rvalid, ifu_rdata, e_irv); end
                checks++; if (lsu_rvalid !== e_lrv || lsu_rdata !== (e_lrv ? mem_rdata : '0)) begin errors++; $display("FAIL rnd_lsu_rsp c%0d: got %0b/%h want %0b", c, lsu_rvalid, lsu_rdata, e_lrv); end
                checks++; if (int'(dut.starve_cnt) != m_starve) begin errors++; $display("FAIL rnd_starve c%0d: got %0d want %0d", c, dut.starve_cnt, m_starve); end
                if (!ifu_req || e_ignt) m_starve = 0;
                else if (e_lgnt && if_ok && m_starve < STARVE_MAX) m_starve++;
                if (m_busy) begin
                    if (!m_lsu && ifu_flush) m_drop = 1;
                    if (!m_acc) begin
                        if (mem_ready) m_acc = 1;
                    end else if (mem_rvalid) begin
                        m_busy = 0;
                        m_drop = 0;
                    end
                end else if (e_lgnt) begin
                    m_busy = 1; m_lsu = 1; m_acc = 0;
                    m_addr = lsu_addr; m_we = lsu_we; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                end else if (e_ignt) begin
                    m_busy = 1; m_lsu = 0; m_acc = 0;
                    m_addr = ifu_addr; m_we = 0; m_wdata = '0; m_wmask = '0;
                end
                prev_ignt = e_ignt;
                prev_lgnt = e_lgnt;
                cyc();
            end
        end
        checks++; if (!finished) begin errors++; $display("FAIL rnd_drain: got busy=%0b want idle", m_busy); end
        auto_mem = 0;
        ifu_req = 0; lsu_req = 0; ifu_flush = 0;
    endtask

    initial begin
        reset = 1;
        ifu_req = 0; ifu_addr = '0; ifu_flush = 0;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_flush_in_flight();
        test_store_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
